// File: rtl/fpga1_transmitter.sv
// Sending side of the FPGA-to-FPGA parallel link: pops fixed-length bursts from a
// show-ahead FIFO and holds each word on data_out for HOLD_CYCLES across the req/rdy/done/ack handshake.
module fpga1_transmitter #(
  parameter int BURST_LEN   = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] src_count,
  input  logic [31:0]      src_rdata,
  output logic             src_rd_en,
  output logic [31:0]      data_out,
  output logic             req_out,
  output logic             send_done,
  input  logic             rdy_in,
  input  logic             ack_in,
  input  logic             err_clr,
  output logic             busy,
  output logic             timeout_err,
  output logic             abort_err,
  output logic [15:0]      burst_cnt
);

  localparam int DATA_W = 32;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int HLD_W  = $clog2(HOLD_CYCLES);
  localparam int WRD_W  = $clog2(BURST_LEN + 1);

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST  = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [WRD_W-1:0] WRD_LAST  = WRD_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] BURST_MIN = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_DONE} state_t;

  state_t             state_q;
  logic               rdy_meta_q, rdy_s_q;
  logic               ack_meta_q, ack_s_q, ack_d_q;
  logic [TMR_W-1:0]   timer_q;
  logic [HLD_W-1:0]   hold_q;
  logic [WRD_W-1:0]   word_q;
  logic [DATA_W-1:0]  data_q;
  logic               req_q, done_q;
  logic [15:0]        bcnt_q;
  logic               tmo_err_q, abt_err_q;
  logic               tmo_err_d, abt_err_d;

  logic ack_rise, start, pop, tmo_hit, abort_hit;

  assign ack_rise  = ack_s_q & ~ack_d_q;
  assign start     = en && (src_count >= BURST_MIN) && !rdy_s_q && !ack_s_q;
  assign abort_hit = (state_q == S_SEND) && !rdy_s_q;
  // Pop is gated by rdy_s so an abort cycle never consumes a word.
  assign pop       = (state_q == S_SEND) && rdy_s_q && (hold_q == HLD_LAST);
  assign tmo_hit   = (timer_q == TMR_LAST) &&
                     (((state_q == S_REQ) && !rdy_s_q) || ((state_q == S_DONE) && !ack_rise));

  assign tmo_err_d = tmo_hit   | (tmo_err_q & ~err_clr);
  assign abt_err_d = abort_hit | (abt_err_q & ~err_clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_d_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
      abt_err_q  <= 1'b0;
    end else begin
      rdy_meta_q <= rdy_in;
      rdy_s_q    <= rdy_meta_q;
      ack_meta_q <= ack_in;
      ack_s_q    <= ack_meta_q;
      ack_d_q    <= ack_s_q;
      tmo_err_q  <= tmo_err_d;
      abt_err_q  <= abt_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      word_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            timer_q <= '0;
          end
        end
        S_REQ: begin
          if (rdy_s_q) begin
            state_q <= S_SEND;
            word_q  <= '0;
            hold_q  <= '0;
            timer_q <= '0;
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_SEND: begin
          if (abort_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            if (hold_q == '0) data_q <= src_rdata;
            if (pop) begin
              hold_q <= '0;
              word_q <= word_q + 1'b1;
              if (word_q == WRD_LAST) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                timer_q <= '0;
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (ack_rise) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            bcnt_q  <= bcnt_q + 1'b1;
            timer_q <= '0;
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_rd_en   = pop;
  assign data_out    = data_q;
  assign req_out     = req_q;
  assign send_done   = done_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = tmo_err_q;
  assign abort_err   = abt_err_q;
  assign burst_cnt   = bcnt_q;

endmodule

// File: tb/tb_fpga1_transmitter.sv
// Directed bench for fpga1_transmitter: a vector table of burst scenarios plus
// hand-written sequences for insufficient data and reset during SEND.
module tb_fpga1_transmitter;

  localparam int BL = 16;
  localparam int H  = 4;
  localparam int TO = 1024;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [CW-1:0] src_count;
  logic [31:0]   src_rdata;
  logic          src_rd_en;
  logic [31:0]   data_out;
  logic          req_out, send_done;
  logic          rdy_in = 1'b0, ack_in = 1'b0, err_clr = 1'b0;
  logic          busy, timeout_err, abort_err;
  logic [15:0]   burst_cnt;

  fpga1_transmitter #(.BURST_LEN(BL), .HOLD_CYCLES(H), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .src_count(src_count), .src_rdata(src_rdata),
    .src_rd_en(src_rd_en), .data_out(data_out), .req_out(req_out), .send_done(send_done),
    .rdy_in(rdy_in), .ack_in(ack_in), .err_clr(err_clr), .busy(busy),
    .timeout_err(timeout_err), .abort_err(abort_err), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  int          rd_ptr = 0;
  int          fill = 0;
  assign src_rdata = mem[rd_ptr];
  assign src_count = CW'(fill - rd_ptr);

  int          n_checks = 0;
  int          n_fail = 0;
  int          pop_cnt = 0;
  int          burst_pops = 0;
  int          last_pop_t = 0;
  int          cyc = 0;
  logic        done_seen = 1'b0;
  logic [31:0] hist1 = '0, hist2 = '0;
  logic [15:0] exp_bcnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // FIFO model and per-pop checks: word order, hold stability, slot spacing.
  always @(negedge clk) begin
    cyc++;
    if (send_done) done_seen = 1'b1;
    if (!busy) burst_pops = 0;
    if (src_rd_en) begin
      check("pop_data", data_out, mem[rd_ptr]);
      check("pop_held", data_out, hist2);
      if (burst_pops > 0) check("pop_spacing", cyc - last_pop_t, H);
      last_pop_t = cyc;
      burst_pops++;
      pop_cnt++;
      rd_ptr++;
    end
    hist2 = hist1;
    hist1 = data_out;
  end

  task automatic wait_sig(input string name, input int which, input logic val,
                          input int budget, output int n);
    logic s;
    bit   hit;
    hit = 0;
    n   = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0:       s = req_out;
        1:       s = send_done;
        2:       s = busy;
        default: s = src_rd_en;
      endcase
      if (s == val) hit = 1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no level %b within %0d cycles", name, val, budget);
      n = -1;
    end
  endtask

  typedef struct {
    string name;
    int    rdy_delay;
    int    drop_after;
    int    ack_delay;
    bit    clr_hold;
    int    exp_pops;
    bit    exp_done;
    bit    exp_tmo;
    bit    exp_abort;
    bit    bcnt_inc;
  } vec_t;

  vec_t vecs [5];

  task automatic run_burst(input vec_t v);
    int n, seen, lim, b0;
    fill      = rd_ptr + BL;
    b0        = pop_cnt;
    done_seen = 1'b0;
    en        = 1'b1;
    wait_sig({v.name, "_req_rise"}, 0, 1'b1, 20, n);
    en = 1'b0;
    if (v.rdy_delay < 0) begin
      n = 0;
      while (req_out === 1'b1 && n < TO + 20) begin
        n++;
        @(negedge clk);
      end
      check({v.name, "_req_len"}, n, TO);
    end else begin
      repeat (v.rdy_delay) @(posedge clk);
      @(posedge clk);
      #1 rdy_in = 1'b1;
      lim  = (v.drop_after >= 0) ? v.drop_after : 1;
      seen = 0;
      n    = 0;
      while (seen < lim && n < 200) begin
        @(negedge clk);
        n++;
        if (src_rd_en) begin
          seen++;
          if (seen == 1) check({v.name, "_first_pop_lat"}, n, 7);
        end
      end
      check({v.name, "_pops_seen"}, seen, lim);
      if (v.drop_after >= 0) begin
        @(posedge clk);
        #1 rdy_in = 1'b0;
        wait_sig({v.name, "_abort_idle"}, 2, 1'b0, 50, n);
      end else begin
        wait_sig({v.name, "_done_rise"}, 1, 1'b1, BL * H + 20, n);
        if (v.ack_delay < 0) begin
          err_clr = v.clr_hold;
          n = 0;
          while (send_done === 1'b1 && n < TO + 20) begin
            n++;
            @(negedge clk);
          end
          check({v.name, "_done_len"}, n, TO);
          err_clr = 1'b0;
          rdy_in  = 1'b0;
        end else begin
          repeat (v.ack_delay) @(posedge clk);
          @(posedge clk);
          #1 ack_in = 1'b1;
          rdy_in = 1'b0;
          @(posedge clk);
          #1 ack_in = 1'b0;
          @(negedge clk);
          @(negedge clk);
          checkb({v.name, "_done_hold"}, send_done, 1'b1);
          @(negedge clk);
          checkb({v.name, "_done_fall"}, send_done, 1'b0);
          checkb({v.name, "_req_fall"}, req_out, 1'b0);
        end
      end
    end
    wait_sig({v.name, "_idle"}, 2, 1'b0, 20, n);
    if (v.bcnt_inc) exp_bcnt = exp_bcnt + 16'd1;
    check({v.name, "_pops"}, pop_cnt - b0, v.exp_pops);
    checkb({v.name, "_done_seen"}, done_seen, v.exp_done);
    checkb({v.name, "_timeout_err"}, timeout_err, v.exp_tmo);
    checkb({v.name, "_abort_err"}, abort_err, v.exp_abort);
    check({v.name, "_burst_cnt"}, 32'(burst_cnt), 32'(exp_bcnt));
    checkb({v.name, "_req_low"}, req_out, 1'b0);
    checkb({v.name, "_done_low"}, send_done, 1'b0);
    if (v.exp_tmo || v.exp_abort) begin
      @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(negedge clk);
      checkb({v.name, "_tmo_cleared"}, timeout_err, 1'b0);
      checkb({v.name, "_abort_cleared"}, abort_err, 1'b0);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, seen, b0;
    logic any_req;
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000 + i;
    vecs[0] = '{"nominal",  4, -1,  1, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"req_tmo", -1, -1, -1, 1'b0,  0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"abort",    4,  5, -1, 1'b0,  5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"done_tmo", 2, -1, -1, 1'b1, 16, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"recovery", 0, -1,  0, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b1};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkb("rst_req", req_out, 1'b0);
    checkb("rst_done", send_done, 1'b0);
    checkb("rst_rd_en", src_rd_en, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    check("rst_data", data_out, 32'h0);
    check("rst_bcnt", 32'(burst_cnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Insufficient data: one word short must never start a burst.
    fill = rd_ptr + BL - 1;
    en   = 1'b1;
    any_req = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (req_out) any_req = 1'b1;
    end
    checkb("short_no_req", any_req, 1'b0);
    checkb("short_idle", busy, 1'b0);
    @(posedge clk);
    #1 fill = fill + 1;
    @(negedge clk);
    checkb("full_req_pre", req_out, 1'b0);
    @(negedge clk);
    checkb("full_req_1cyc", req_out, 1'b1);

    for (int i = 0; i < 5; i++) run_burst(vecs[i]);

    // Reset in the middle of a word during SEND.
    fill = rd_ptr + BL;
    en   = 1'b1;
    wait_sig("rs_req", 0, 1'b1, 20, n);
    en = 1'b0;
    @(posedge clk);
    #1 rdy_in = 1'b1;
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (src_rd_en) seen++;
    end
    check("rs_pops_before", seen, 2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkb("rs_req_low", req_out, 1'b0);
    checkb("rs_done_low", send_done, 1'b0);
    checkb("rs_rd_en_low", src_rd_en, 1'b0);
    checkb("rs_busy_low", busy, 1'b0);
    check("rs_data_zero", data_out, 32'h0);
    check("rs_bcnt_zero", 32'(burst_cnt), 32'h0);
    exp_bcnt = '0;
    b0     = pop_cnt;
    rdy_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rs_no_pop", pop_cnt - b0, 0);
    checkb("rs_idle", busy, 1'b0);
    run_burst(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
